operand_issue_ctrl: RTL
=======================

OPERAND_ISSUE_CTRL -- requirements
Module: operand_issue_ctrl

Interface
REQ-001 Parameter: GAP_CYCLES, default 1, number of idle cycles (all sel low) inserted between consecutive issues; legal range 0..7.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: cmd_valid  input  1  command present.
REQ-005 Port: cmd_ready  output  1  block can accept a command this cycle.
REQ-006 Port: cmd_op  input  2  operation select: 0..3 map to sel1..sel4.
REQ-007 Port: cmd_a  input  4  operand A.
REQ-008 Port: cmd_b  input  4  operand B.
REQ-009 Port: cmd_len  input  3  issue duration minus one; the operation is held for cmd_len+1 cycles.
REQ-010 Port: a  output  4  registered operand A to the datapath.
REQ-011 Port: b  output  4  registered operand B to the datapath.
REQ-012 Port: sel1, sel2, sel3, sel4  output  1 each  registered operation selects to the datapath.
REQ-013 Port: busy  output  1  high in ISSUE or GAP state.
REQ-014 Port: done  output  1  one-cycle pulse on the final cycle of each issue.

Function
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1, and written into a 2-entry FIFO as {op, a, b, len}.
REQ-016 cmd_ready SHALL equal (FIFO count < 2), registered state only; there SHALL be no bypass, so a push is refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-017 Simultaneous push and pop with count 1 SHALL leave count at 1 with FIFO order preserved.
REQ-018 The FSM SHALL have three states: IDLE, ISSUE, GAP.
REQ-019 IDLE -> ISSUE SHALL occur on the edge after the FIFO becomes non-empty; on that edge the head entry is popped and loaded into a, b, sel*, and the hold counter is set to len.
REQ-020 Command-accept-to-sel latency SHALL be exactly 2 edges from an empty, idle state: accepted at edge N, sel visible after edge N+1.
REQ-021 In ISSUE, exactly one of sel1..sel4 SHALL be high, chosen by op; the counter decrements each cycle.
REQ-022 The final ISSUE cycle (counter=0) SHALL assert done.
REQ-023 From the final ISSUE cycle, the FSM SHALL go to GAP if GAP_CYCLES>0. If GAP_CYCLES=0, it SHALL go to ISSUE, loading the next entry, when the FIFO is non-empty, and otherwise to IDLE.
REQ-024 GAP SHALL last GAP_CYCLES cycles with all sel low. It SHALL then go to ISSUE, with a load, when the FIFO is non-empty, and otherwise to IDLE.
REQ-025 In IDLE and GAP, all sel SHALL be 0, and a and b SHALL hold their last loaded values unchanged.
REQ-026 a and b SHALL change only on an ISSUE load edge, so downstream operands do not toggle while unselected.
REQ-027 At most one sel SHALL be high at any time, including across state transitions.

Reset
REQ-028 While rst=1, the following SHALL be 0 immediately and asynchronously: a, b, sel1..sel4, busy, done, cmd_ready, FIFO count, and hold/gap counters; the FSM SHALL be in IDLE.
REQ-029 cmd_ready SHALL rise on the first edge after rst deasserts.
REQ-030 Reset asserted mid-ISSUE or mid-GAP SHALL discard the active command and all FIFO contents; no done SHALL be produced for the aborted command.

Verification
REQ-031 Reset check: hold rst=1 for 3 cycles, then release -> all outputs 0 during reset; cmd_ready=1 one edge after release.
REQ-032 Single issue: op=2, a=8, b=2, len=1 into idle -> sel3=1, a=8, b=2 for 2 cycles starting 2 edges after accept; done on the 2nd cycle; 1 gap cycle; then IDLE with a=8, b=2 held.
REQ-033 Back-pressure: present 4 commands back-to-back (ops 0,1,2,3; len=0) with cmd_valid held -> cmd_ready drops when FIFO is full; sel1, sel2, sel3, sel4 each pulse 1 cycle in order, separated by 1 gap cycle; no command lost or duplicated.
REQ-034 Zero-gap: with GAP_CYCLES=0, issue two commands (op=0, len=2 and op=3, len=0) -> sel1 high 3 cycles, then sel4 high 1 cycle with no idle cycle between; never two sels high at once.
REQ-035 Abort: assert rst in the 2nd cycle of an op=1, len=4 issue with one entry queued -> sel2 falls immediately; no done; after release the FIFO is empty and no issue occurs.
REQ-036 Stability: over 20 idle cycles after any issue -> zero toggles on a, b, and sel1..sel4.

Source files
------------

// File: rtl/operand_issue_ctrl.sv
// Operand issue controller: buffers up to two commands and drives registered
// operands and a one-hot operation select per issue, with optional idle gaps.
module operand_issue_ctrl #(
  parameter  int unsigned GAP_CYCLES = 1,
  localparam int unsigned OP_W       = 2,
  localparam int unsigned D_W        = 4,
  localparam int unsigned LEN_W      = 3,
  localparam int unsigned SEL_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [D_W-1:0]   cmd_a,
  input  logic [D_W-1:0]   cmd_b,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [D_W-1:0]   a,
  output logic [D_W-1:0]   b,
  output logic             sel1,
  output logic             sel2,
  output logic             sel3,
  output logic             sel4,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [D_W-1:0]   a;
    logic [D_W-1:0]   b;
    logic [LEN_W-1:0] len;
  } cmd_t;

  localparam bit               HAS_GAP  = (GAP_CYCLES != 0);
  localparam logic [LEN_W-1:0] GAP_LOAD = LEN_W'(GAP_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  cmd_t             r_fifo [2];
  cmd_t             w_head;
  logic             r_wptr, r_rptr;
  logic [1:0]       r_count, w_count_nxt;
  logic             r_ready;
  logic [LEN_W-1:0] r_hold, w_hold_nxt;
  logic [LEN_W-1:0] r_gap, w_gap_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [D_W-1:0]   r_a, r_b;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_push, w_pop, w_fifo_ne;

  assign w_push    = cmd_valid & r_ready;
  assign w_fifo_ne = (r_count != 2'd0);
  assign w_head    = r_fifo[r_rptr];

  // FIFO storage; only entries below the count are ever read
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= {cmd_op, cmd_a, cmd_b, cmd_len};
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Ready is a registered image of the post-edge count, so pops never bypass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < 2'd2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state; w_pop marks every edge that loads a new issue
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_ne) begin
          w_state_nxt = S_ISSUE;
          w_pop       = 1'b1;
        end
      end
      S_ISSUE: begin
        if (r_hold == '0) begin
          if (HAS_GAP) begin
            w_state_nxt = S_GAP;
          end else if (w_fifo_ne) begin
            w_state_nxt = S_ISSUE;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          if (w_fifo_ne) begin
            w_state_nxt = S_ISSUE;
            w_pop       = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for counters and registered outputs
  always_comb begin
    w_hold_nxt = r_hold;
    w_gap_nxt  = r_gap;
    w_sel_nxt  = '0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = 1'b0;
    if (w_pop) begin
      w_hold_nxt = w_head.len;
      w_sel_nxt  = SEL_W'(1) << w_head.op;
    end else if (w_state_nxt == S_ISSUE) begin
      w_hold_nxt = r_hold - LEN_W'(1);
      w_sel_nxt  = r_sel;
    end else if (w_state_nxt == S_GAP) begin
      w_gap_nxt = (r_state == S_ISSUE) ? GAP_LOAD : r_gap - LEN_W'(1);
    end
    w_done_nxt = (w_state_nxt == S_ISSUE) && (w_hold_nxt == '0);
  end

  // Operands move only on a load edge so the datapath sees no idle toggling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_gap  <= '0;
      r_sel  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
    end else begin
      r_hold <= w_hold_nxt;
      r_gap  <= w_gap_nxt;
      r_sel  <= w_sel_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_pop) begin
        r_a <= w_head.a;
        r_b <= w_head.b;
      end
    end
  end

  assign cmd_ready                = r_ready;
  assign a                        = r_a;
  assign b                        = r_b;
  assign {sel4, sel3, sel2, sel1} = r_sel;
  assign busy                     = r_busy;
  assign done                     = r_done;

endmodule
